// File: rtl/mips_defs.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, divider sizing.
package mips_defs;

   localparam int DATA_W    = 32;
   localparam int DIV_ITERS = 32;
   localparam int DIV_CNT_W = $clog2(DIV_ITERS);

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_DIV  = 2'b01,
      ST_SIGN = 2'b10,
      ST_DONE = 2'b11
   } muldiv_state_e;

   // Two's complement negate when neg is set; -(2^31) maps onto itself, which is the
   // correct unsigned magnitude for the most negative operand.
   function automatic logic [DATA_W-1:0] conditional_negate(input logic [DATA_W-1:0] v,
                                                            input logic              neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_radix2.sv
// Restoring radix-2 divider datapath on unsigned magnitudes, one quotient bit per step.
// Result valid DIV_ITERS steps after load; no backpressure, the owning FSM sequences load/step.
module div_radix2 import mips_defs::*; (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] quo_q;
   logic [DATA_W-1:0] dsr_q;
   logic [DATA_W:0]   shifted;
   logic [DATA_W:0]   diff;

   // The dividend shifts out of the quotient register MSB-first while quotient bits shift in.
   assign shifted = {rem_q, quo_q[DATA_W-1]};
   assign diff    = shifted - {1'b0, dsr_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dsr_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dsr_q <= divisor;
      end else if (step) begin
         // Since rem < divisor, a borrow out of bit DATA_W means shifted < divisor.
         if (diff[DATA_W]) begin
            rem_q <= shifted[DATA_W-1:0];
            quo_q <= {quo_q[DATA_W-2:0], 1'b0};
         end else begin
            rem_q <= diff[DATA_W-1:0];
            quo_q <= {quo_q[DATA_W-2:0], 1'b1};
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO unit: single-cycle MULT/MULTU, 33-cycle iterative DIV/DIVU, MTHI/MTLO writes.
// Latency: mult and divide-by-zero done next cycle, divide done 34 cycles after start; busy stalls the pipe.
module muldiv_unit import mips_defs::*; (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] data_a,
   input  logic [DATA_W-1:0] data_b,
   input  logic              cancel,
   input  logic              wr_hi,
   input  logic              wr_lo,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   muldiv_state_e        state_q;
   muldiv_state_e        state_d;
   muldiv_op_e           op_sel;
   logic [DIV_CNT_W-1:0] cnt_q;
   logic                 neg_quo_q;
   logic                 neg_rem_q;

   logic                 accept;
   logic                 is_mul;
   logic                 div_signed;
   logic                 div_by_zero;
   logic                 div_load;
   logic                 div_step;
   logic                 sign_commit;
   logic                 last_iter;

   logic [2*DATA_W-1:0]  mul_a;
   logic [2*DATA_W-1:0]  mul_b;
   logic [2*DATA_W-1:0]  product;
   logic [DATA_W-1:0]    mag_a;
   logic [DATA_W-1:0]    mag_b;
   logic [DATA_W-1:0]    quo_raw;
   logic [DATA_W-1:0]    rem_raw;
   logic [DATA_W-1:0]    quo_fix;
   logic [DATA_W-1:0]    rem_fix;

   assign op_sel      = muldiv_op_e'(op);
   assign accept      = start && (state_q == ST_IDLE);
   assign is_mul      = (op_sel == OP_MULT) || (op_sel == OP_MULTU);
   assign div_signed  = (op_sel == OP_DIV);
   assign div_by_zero = (data_b == '0);
   assign last_iter   = (cnt_q == DIV_CNT_W'(DIV_ITERS - 1));

   // A 64x64 multiply of the extended operands gives the correct low 64 bits for both signednesses.
   assign mul_a   = (op_sel == OP_MULT) ? {{DATA_W{data_a[DATA_W-1]}}, data_a} : {{DATA_W{1'b0}}, data_a};
   assign mul_b   = (op_sel == OP_MULT) ? {{DATA_W{data_b[DATA_W-1]}}, data_b} : {{DATA_W{1'b0}}, data_b};
   assign product = mul_a * mul_b;

   assign mag_a = conditional_negate(data_a, div_signed && data_a[DATA_W-1]);
   assign mag_b = conditional_negate(data_b, div_signed && data_b[DATA_W-1]);

   div_radix2 u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .step      (div_step),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (quo_raw),
      .remainder (rem_raw)
   );

   assign quo_fix = conditional_negate(quo_raw, neg_quo_q);
   assign rem_fix = conditional_negate(rem_raw, neg_rem_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      div_load    = 1'b0;
      div_step    = 1'b0;
      sign_commit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_mul || div_by_zero) begin
                  state_d = ST_DONE;
               end else begin
                  state_d  = ST_DIV;
                  div_load = 1'b1;
               end
            end
         end
         ST_DIV: begin
            if (cancel) begin
               state_d = ST_IDLE;
            end else begin
               div_step = 1'b1;
               if (last_iter) begin
                  state_d = ST_SIGN;
               end
            end
         end
         ST_SIGN: begin
            if (cancel) begin
               state_d = ST_IDLE;
            end else begin
               sign_commit = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (div_load) begin
         cnt_q <= '0;
      end else if (div_step) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Sign fixup flags are captured at start so later op/operand changes cannot disturb them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else if (div_load) begin
         neg_quo_q <= div_signed && (data_a[DATA_W-1] ^ data_b[DATA_W-1]);
         neg_rem_q <= div_signed && data_a[DATA_W-1];
      end
   end

   // Later assignments take priority: a same-edge multiply or divide-by-zero result beats MTHI/MTLO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else begin
         if (!busy) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
         end
         if (accept && is_mul) begin
            hi <= product[2*DATA_W-1:DATA_W];
            lo <= product[DATA_W-1:0];
         end else if (accept && div_by_zero) begin
            hi <= data_a;
            lo <= '1;
         end else if (sign_commit) begin
            hi <= rem_fix;
            lo <= quo_fix;
         end
      end
   end

   assign busy = (state_q == ST_DIV) || (state_q == ST_SIGN);
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {hi,lo,done cycle}, a monitor pops on done.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] data_a;
   logic [31:0] data_b;
   logic        cancel;
   logic        wr_hi;
   logic        wr_lo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   muldiv_unit dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .data_a (data_a),
      .data_b (data_b),
      .cancel (cancel),
      .wr_hi  (wr_hi),
      .wr_lo  (wr_lo),
      .wdata  (wdata),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
      string       name;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Architectural reference: returns {hi, lo} using plain integer arithmetic.
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      longint          sa, sb, sp, sq, sr;
      longint unsigned ua, ub, up, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (o)
         2'b00: begin sp = sa * sb; return 64'(sp); end
         2'b01: begin up = ua * ub; return up; end
         default: begin
            if (b == 32'h0) return {a, 32'hFFFFFFFF};
            if (o == 2'b10) begin
               sq = sa / sb;
               sr = sa % sb;
               return {sr[31:0], sq[31:0]};
            end
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   exp_t mon_e;
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, expected no completion", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, "_hi"}, hi, mon_e.hi);
            check({mon_e.name, "_lo"}, lo, mon_e.lo);
            check({mon_e.name, "_done_cycle"}, cyc, mon_e.cyc);
         end
      end
   end

   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit whi, input bit wlo,
                         input logic [31:0] wd, input bit inject);
      logic [63:0] r;
      exp_t        e;
      int          busy_n;
      bit          seen;
      bit          long_div;
      r        = ref_result(o, a, b);
      long_div = o[1] && (b != 32'h0);
      @(posedge clk); #1;
      start  = 1'b1;
      op     = o;
      data_a = a;
      data_b = b;
      wr_hi  = whi;
      wr_lo  = wlo;
      wdata  = wd;
      if (whi) m_hi = wd;
      if (wlo) m_lo = wd;
      e.hi   = r[63:32];
      e.lo   = r[31:0];
      e.cyc  = cyc + (long_div ? 34 : 1);
      e.name = name;
      exp_q.push_back(e);
      busy_n = 0;
      seen   = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         start  = inject && (i == 3);
         op     = 2'b00;
         data_a = $urandom;
         data_b = $urandom;
         wr_hi  = 1'b0;
         wr_lo  = 1'b0;
         @(negedge clk);
         if (i == 0 && long_div) begin
            check({name, "_early_hi"}, hi, m_hi);
            check({name, "_early_lo"}, lo, m_lo);
         end
         if (busy) busy_n++;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check({name, "_done_seen"}, 32'(seen), 32'd1);
      check({name, "_busy_cycles"}, busy_n, long_div ? 32'd33 : 32'd0);
      @(negedge clk);
      check({name, "_done_one_cycle"}, 32'(done), 32'd0);
      m_hi = r[63:32];
      m_lo = r[31:0];
   endtask

   task automatic abort_div(input bit use_rst);
      int d_n;
      @(posedge clk); #1;
      wr_hi = 1'b1;
      wdata = 32'h11111111;
      @(posedge clk); #1;
      wr_hi = 1'b0;
      m_hi  = 32'h11111111;
      @(negedge clk);
      check("preload_hi", hi, m_hi);
      @(posedge clk); #1;
      start  = 1'b1;
      op     = 2'b10;
      data_a = 32'h12345678;
      data_b = 32'h00000007;
      // Eleven edges: the accepting one plus ten iterations, leaving the counter at 10.
      for (int k = 0; k < 11; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         wr_hi = (k == 4);
         wdata = 32'h22222222;
      end
      wr_hi = 1'b0;
      if (!use_rst) begin
         cancel = 1'b1;
         @(posedge clk); #1;
         cancel = 1'b0;
         check("cancel_busy", 32'(busy), 32'd0);
         check("cancel_hi", hi, 32'h11111111);
         check("cancel_lo", lo, m_lo);
      end else begin
         rst = 1'b1;
         #1;
         check("rst_mid_hi", hi, 32'h0);
         check("rst_mid_lo", lo, 32'h0);
         check("rst_mid_busy", 32'(busy), 32'd0);
         m_hi = '0;
         m_lo = '0;
         @(posedge clk); #1;
         rst = 1'b0;
      end
      d_n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) d_n++;
      end
      check(use_rst ? "rst_no_done" : "cancel_no_done", d_n, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      op     = 2'b00;
      data_a = '0;
      data_b = '0;
      cancel = 1'b0;
      wr_hi  = 1'b0;
      wr_lo  = 1'b0;
      wdata  = '0;
      #12;
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_op("mult_neg", 2'b00, 32'hFFFFFFFE, 32'h00000003, 0, 0, '0, 0);
      check("mult_neg_hi_const", hi, 32'hFFFFFFFF);
      check("mult_neg_lo_const", lo, 32'hFFFFFFFA);
      run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'h00000002, 0, 0, '0, 0);
      check("multu_hi_const", hi, 32'h00000001);
      check("multu_lo_const", lo, 32'hFFFFFFFE);
      run_op("div_m7", 2'b10, 32'hFFFFFFF9, 32'h00000002, 0, 0, '0, 1);
      check("div_m7_lo_const", lo, 32'hFFFFFFFD);
      check("div_m7_hi_const", hi, 32'hFFFFFFFF);
      run_op("divu_zero", 2'b11, 32'h00000064, 32'h00000000, 0, 0, '0, 0);
      check("divu_zero_lo_const", lo, 32'hFFFFFFFF);
      check("divu_zero_hi_const", hi, 32'h00000064);
      run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, '0, 0);
      check("div_ovf_lo_const", lo, 32'h80000000);
      check("div_ovf_hi_const", hi, 32'h00000000);

      run_op("mult_vs_wr", 2'b00, 32'h00000007, 32'hFFFFFFFD, 1, 1, 32'hDEADBEEF, 0);
      run_op("divu_with_wr", 2'b11, 32'h000003E8, 32'h00000007, 0, 1, 32'hCAFEF00D, 0);

      @(posedge clk); #1;
      wr_hi = 1'b1;
      wr_lo = 1'b1;
      wdata = 32'hA5A5A5A5;
      @(posedge clk); #1;
      wr_hi = 1'b0;
      wr_lo = 1'b0;
      @(negedge clk);
      check("mthi", hi, 32'hA5A5A5A5);
      check("mtlo", lo, 32'hA5A5A5A5);
      m_hi = 32'hA5A5A5A5;
      m_lo = 32'hA5A5A5A5;

      abort_div(1'b0);
      run_op("after_cancel", 2'b01, 32'h00010000, 32'h00010000, 0, 0, '0, 0);
      abort_div(1'b1);
      run_op("after_rst", 2'b10, 32'h00000064, 32'hFFFFFFF9, 0, 0, '0, 0);

      cancel = 1'b1;
      run_op("mult_cancel_idle", 2'b00, 32'h80000000, 32'h80000000, 0, 0, '0, 0);
      run_op("div0_cancel_idle", 2'b10, 32'hFFFFFFF0, 32'h00000000, 0, 0, '0, 0);
      cancel = 1'b0;

      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: b = b >> $urandom_range(0, 31);
            2: a = {1'b1, 31'h0};
            default: ;
         endcase
         run_op("rand", 2'($urandom_range(0, 3)), a, b, ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 3) == 0));
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
